mm2s_stream_tx: RTL and testbench

Stream transmitter at the output end of the MM2S DMA path. Accepts a transfer command carrying a byte length, drains exactly the required number of words from the data FIFO pop side, and emits them as an AXI-Stream-style beat sequence with byte-accurate `m_tkeep` and `m_tlast`. One registered output stage decouples the FIFO from the downstream consumer. Signals completion with a one-cycle `done` pulse.

---
 rtl/mm2s_pkg.sv | 30 +++
 rtl/mm2s_stream_tx.sv | 163 ++++++++++++++++
 tb/tb_mm2s_stream_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm2s_pkg.sv
// rtl/mm2s_pkg.sv - shared types and helpers for the MM2S stream transmitter
package mm2s_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } tx_state_t;

    localparam int DEF_DATA_W = 64;
    localparam int MAX_KEEP_W = 128;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    localparam int BYTES = bytes_of(DEF_DATA_W);

    // A zero remainder means the final beat is full.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input logic [31:0] len_remainder);
        logic [MAX_KEEP_W-1:0] m;
        if (len_remainder == 32'd0) begin
            m = '1;
        end else begin
            m = (MAX_KEEP_W'(1) << len_remainder) - MAX_KEEP_W'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/mm2s_stream_tx.sv
// rtl/mm2s_stream_tx.sv - MM2S FIFO-to-stream transmitter; MM2S_TX_STATS_EN adds stall_cnt
module mm2s_stream_tx
    import mm2s_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                fifo_valid,
    output logic                fifo_ready,
    input  logic [DATA_W-1:0]   fifo_data,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tlast,
    output logic                busy,
    output logic                done
`ifdef MM2S_TX_STATS_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int KEEP_W = bytes_of(DATA_W);
    localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(KEEP_W);

    tx_state_t           state_q, state_d;
    logic [LEN_W-1:0]    beats_left_q, beats_left_d;
    logic [KEEP_W-1:0]   last_keep_q, last_keep_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]   m_tkeep_q, m_tkeep_d;
    logic                m_tlast_q, m_tlast_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]      len_rem;
    logic [LEN_W-1:0]      len_beats;
    logic [MAX_KEEP_W-1:0] len_keep_full;
    logic                  unused_keep_hi;
    logic                  cmd_accept;
    logic                  pop;
    logic                  out_accept;
    logic                  pop_is_last;

    assign len_rem        = cmd_len % BYTES_L;
    assign len_beats      = (cmd_len / BYTES_L) + LEN_W'(len_rem != '0);
    assign len_keep_full  = keep_mask(32'(len_rem));
    assign unused_keep_hi = ^len_keep_full[MAX_KEEP_W-1:KEEP_W];

    assign cmd_accept  = cmd_valid && cmd_ready;
    assign pop         = fifo_valid && fifo_ready;
    assign out_accept  = m_tvalid_q && m_tready;
    assign pop_is_last = (beats_left_q == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            last_keep_q  <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tlast_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            last_keep_q  <= last_keep_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        last_keep_d  = last_keep_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tlast_d    = m_tlast_q;
        done_d       = 1'b0;

        // A pop refills the output register even when the current beat leaves this cycle.
        if (pop) begin
            m_tvalid_d   = 1'b1;
            m_tdata_d    = fifo_data;
            m_tkeep_d    = pop_is_last ? last_keep_q : '1;
            m_tlast_d    = pop_is_last;
            beats_left_d = beats_left_q - LEN_W'(1);
        end else if (out_accept) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = STREAM;
                        beats_left_d = len_beats;
                        last_keep_d  = len_keep_full[KEEP_W-1:0];
                    end
                end
            end
            STREAM: begin
                if (pop && pop_is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_accept && m_tlast_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        fifo_ready = (state_q == STREAM) && (beats_left_q != '0) && (!m_tvalid_q || m_tready);
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign done     = done_q;

`ifdef MM2S_TX_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_tvalid_q && !m_tready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mm2s_stream_tx.sv
// tb/tb_mm2s_stream_tx.sv - scoreboard bench for mm2s_stream_tx (DATA_W=64)
module tb_mm2s_stream_tx;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_len;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [63:0] fifo_data;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        busy;
    logic        done;
`ifdef MM2S_TX_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] fifo_q[$];
    beat_t       exp_q[$];
    logic        fifo_gate = 1'b0;
    logic        pop_pend = 1'b0;
    logic        tgl = 1'b0;

    int cyc = 0, beat_cnt = 0, pop_cnt = 0, done_count = 0;
    int done_cyc = 0, last_acc_cyc = 0, model_stalls = 0;
    logic        gap_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    always #5 clk = ~clk;

    mm2s_stream_tx #(.DATA_W(64), .LEN_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready),
        .fifo_data  (fifo_data),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .busy       (busy),
`ifdef MM2S_TX_STATS_EN
        .stall_cnt  (stall_cnt),
`endif
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_valid = (fifo_q.size() > 0) && !fifo_gate;
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
    endtask

    // Downstream monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            model_stalls = 0;
            prev_stall   = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", m_tdata, prev_data);
                check("hold_keep", 64'(m_tkeep), 64'(prev_keep));
                check("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && !m_tready) check("no_pop_stalled", 64'(fifo_ready), 64'd0);
            if (m_tvalid && m_tready) begin
                check("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", m_tdata, e.d);
                    check("beat_keep", 64'(m_tkeep), 64'(e.k));
                    check("beat_last", 64'(m_tlast), 64'(e.l));
                end
                beat_cnt++;
                if (m_tlast) last_acc_cyc = cyc;
            end
            if (fifo_valid && fifo_ready) begin
                pop_cnt++;
                pop_pend = 1'b1;
            end
            if (!m_tvalid && busy) gap_seen = 1'b1;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_keep  = m_tkeep;
            prev_last  = m_tlast;
            if (m_tvalid && !m_tready) model_stalls++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_pend = 1'b0;
            refresh_fifo();
        end
        if (tgl) m_tready = ~m_tready;
    end

    task automatic push_xfer(input int len, input int extra);
        int nb;
        int rem;
        logic [63:0] w;
        logic [7:0]  lk;
        nb  = (len + 7) / 8;
        rem = len % 8;
        lk  = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
        for (int i = 0; i < nb + extra; i++) begin
            w = {$urandom, $urandom};
            fifo_q.push_back(w);
            if (i < nb) exp_q.push_back('{d: w, k: (i == nb - 1) ? lk : 8'hFF, l: (i == nb - 1)});
        end
        refresh_fifo();
    endtask

    task automatic send_cmd(input int len);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = 24'(len);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!cmd_ready && n < 50);
        check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic chk_latency);
        int start;
        int n;
        start = done_count;
        n = 0;
        while (done_count == start && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_seen", 64'(done_count != start), 64'd1);
        if (chk_latency && done_count != start)
            check("done_latency", 64'(done_cyc - last_acc_cyc), 64'd1);
        check("idle_at_done", 64'(cmd_ready), 64'd1);
        @(negedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic finish_xfer(input int len, input int extra, input int b0, input int p0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("beat_total", 64'(beat_cnt - b0), 64'((len + 7) / 8));
        check("pop_total", 64'(pop_cnt - p0), 64'((len + 7) / 8));
        check("fifo_left", 64'(fifo_q.size()), 64'(extra));
        @(posedge clk); #1;
        fifo_q.delete();
        refresh_fifo();
    endtask

    task automatic run_xfer(input int len, input int extra);
        int b0;
        int p0;
        b0 = beat_cnt;
        p0 = pop_cnt;
        push_xfer(len, extra);
        send_cmd(len);
        wait_done(len != 0);
        finish_xfer(len, extra, b0, p0);
    endtask

    initial begin
        int b0;
        int p0;
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        m_tready = 1'b1;
        refresh_fifo();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_fifo_ready", 64'(fifo_ready), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);
        check("rst_tkeep", 64'(m_tkeep), 64'd0);
`ifdef MM2S_TX_STATS_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        run_xfer(16, 0);
        run_xfer(13, 1);
        run_xfer(1, 0);
        run_xfer(0, 1);

        // Backpressure: ready toggles every cycle.
        @(posedge clk); #1;
        tgl = 1'b1;
        run_xfer(64, 0);
        @(posedge clk); #1;
        tgl = 1'b0;
        m_tready = 1'b1;
        @(negedge clk); #1;
`ifdef MM2S_TX_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(model_stalls));
`endif

        // FIFO empty window mid-transfer.
        b0 = beat_cnt;
        p0 = pop_cnt;
        push_xfer(32, 0);
        send_cmd(32);
        n = 0;
        while (beat_cnt < b0 + 1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("first_beat_seen", 64'(beat_cnt >= b0 + 1), 64'd1);
        @(posedge clk); #1;
        gap_seen = 1'b0;
        fifo_gate = 1'b1;
        refresh_fifo();
        repeat (3) @(posedge clk);
        #1;
        fifo_gate = 1'b0;
        refresh_fifo();
        wait_done(1'b1);
        check("gap_seen", 64'(gap_seen), 64'd1);
        finish_xfer(32, 0, b0, p0);

        // Reset in the middle of an 8-beat transfer.
        p0 = pop_cnt;
        push_xfer(64, 0);
        send_cmd(64);
        n = 0;
        while (pop_cnt < p0 + 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("third_pop_seen", 64'(pop_cnt >= p0 + 3), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        refresh_fifo();
        @(negedge clk); #1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_fifo_ready", 64'(fifo_ready), 64'd0);
        run_xfer(8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
